page_stream_tx: RTL and testbench

PAGE_STREAM_TX -- requirements
Module: page_stream_tx

---
 rtl/page_pkg.sv | 22 ++
 rtl/page_stream_tx_if.sv | 27 ++
 rtl/page_counter64.sv | 31 +++
 rtl/page_stream_tx.sv | 122 ++++++++++++
 tb/tb_page_stream_tx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/page_pkg.sv
// Shared constants and types for the page streamer: page geometry, FSM encoding and
// the lane-major layout of the captured state (lane l occupies bits [LANE_W*l +: LANE_W]).
package page_pkg;

  localparam int unsigned NUM_PAGES = 64;
  localparam int unsigned PAGE_W    = 25;
  localparam int unsigned IDX_W     = 6;

  // Lane-to-page mapping: page z, bit l is bit (LANE_W*l + z) of the state vector.
  localparam int unsigned LANE_W    = NUM_PAGES;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAGES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPreroll,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/page_stream_tx_if.sv
// Output handshake bundle of the page streamer: one page per beat, valid/ready flow control.
interface page_stream_tx_if;
  import page_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [PAGE_W-1:0] out_page;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_page,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_page,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/page_counter64.sv
// Six-bit page counter with synchronous clear and increment enable; wraps 63 -> 0.
module page_counter64 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [5:0] count_o
);

  logic [5:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/page_stream_tx.sv
// Captures a 1600-bit state and streams it out as 64 slices of 25 bits over valid/ready.
// Optional macro PAGE_STREAM_PREROLL_EN prepends a copy of slice 63 before slice 0.
module page_stream_tx #(
  parameter int unsigned NUM_PAGES = page_pkg::NUM_PAGES,
  parameter int unsigned PAGE_W    = page_pkg::PAGE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [PAGE_W*NUM_PAGES-1:0] state_in,
  page_stream_tx_if.master            tx,
  output logic                        busy,
  output logic                        done
);
  import page_pkg::*;

  state_e state_q, state_d;
  logic [PAGE_W*NUM_PAGES-1:0] buf_q, buf_d;

  logic       cnt_clr, cnt_en;
  logic [5:0] cnt;
  logic [5:0] sel_z;

  logic [NUM_PAGES-1:0] lanes [PAGE_W];
  logic [PAGE_W-1:0]    cur_page;

  logic              valid;
  logic [PAGE_W-1:0] page;
  logic [5:0]        index;
  logic              last;

  page_counter64 u_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt)
  );

  // Preroll replays the top slice so the consumer already holds z=63 when z=0 arrives.
  assign sel_z = (state_q == StPreroll) ? LAST_IDX : cnt;

  for (genvar g = 0; g < PAGE_W; g++) begin : gen_lane
    assign lanes[g]    = buf_q[g*NUM_PAGES +: NUM_PAGES];
    assign cur_page[g] = lanes[g][sel_z];
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    valid   = 1'b0;
    page    = '0;
    index   = '0;
    last    = 1'b0;
    done    = 1'b0;
    busy    = (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (start) begin
          buf_d   = state_in;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_clr = 1'b1;
`ifdef PAGE_STREAM_PREROLL_EN
        state_d = StPreroll;
`else
        state_d = StSend;
`endif
      end
`ifdef PAGE_STREAM_PREROLL_EN
      StPreroll: begin
        valid = 1'b1;
        page  = cur_page;
        index = LAST_IDX;
        if (tx.out_ready) begin
          state_d = StSend;
        end
      end
`endif
      StSend: begin
        valid = 1'b1;
        page  = cur_page;
        index = cnt;
        last  = (cnt == LAST_IDX);
        if (tx.out_ready) begin
          cnt_en = 1'b1;
          if (last) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  assign tx.out_valid = valid;
  assign tx.out_page  = page;
  assign tx.out_index = index;
  assign tx.out_last  = last;

endmodule

// File: tb/tb_page_stream_tx.sv
// Randomized bench for page_stream_tx: a queue of expected beats is derived from the captured
// state and checked beat by beat under various ready patterns, resets and ignored starts.
module tb_page_stream_tx;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1599:0] state_in;
  logic          busy;
  logic          done;

  page_stream_tx_if tx_if ();

  page_stream_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .state_in (state_in),
    .tx       (tx_if),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] page_of(input logic [1599:0] st, input int z);
    logic [24:0] p;
    for (int l = 0; l < 25; l++) p[l] = st[64*l + z];
    return p;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int w = 0; w < 50; w++) s[32*w +: 32] = $urandom;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rdy_mode: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  task automatic run_xfer(input logic [1599:0] st, input int rdy_mode, input bit abort,
                          input bit poke);
    int          exp_idx[$];
    logic [24:0] exp_pg[$];
    int          total, beats, cyc;
    bit          hs;
    bit          rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

`ifdef PAGE_STREAM_PREROLL_EN
    exp_idx.push_back(63);
    exp_pg.push_back(page_of(st, 63));
`endif
    for (int z = 0; z < 64; z++) begin
      exp_idx.push_back(z);
      exp_pg.push_back(page_of(st, z));
    end
    total = exp_idx.size();

    state_in = st;
    start    = 1'b1;
    step();
    start = 1'b0;
    check_eq("load_busy", busy, 1);
    check_eq("load_valid", tx_if.out_valid, 0);
    step();
    check_eq("first_valid", tx_if.out_valid, 1);

    beats = 0;
    cyc   = 0;
    while (exp_idx.size() > 0 && cyc < 2000) begin
      case (rdy_mode)
        0:       tx_if.out_ready = 1'b1;
        1:       tx_if.out_ready = rdy_pat[cyc % 4];
        default: tx_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && (cyc % 17 == 5)) begin
        start    = 1'b1;
        state_in = rand_state();
      end else begin
        start = 1'b0;
      end

      check_eq("valid", tx_if.out_valid, 1);
      check_eq("index", tx_if.out_index, exp_idx[0]);
      check_eq("page", tx_if.out_page, exp_pg[0]);
      check_eq("last", tx_if.out_last, (exp_idx.size() == 1));
      check_eq("no_done", done, 0);

      if (abort && tx_if.out_index == 6'd30) begin
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_valid", tx_if.out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_index", tx_if.out_index, 0);
        check_eq("rst_page", tx_if.out_page, 0);
        for (int i = 0; i < 3; i++) begin
          step();
          check_eq("rst_no_done", done, 0);
          check_eq("rst_idle", busy, 0);
        end
        return;
      end

      hs = tx_if.out_valid && tx_if.out_ready;
      step();
      cyc++;
      if (hs) begin
        void'(exp_idx.pop_front());
        void'(exp_pg.pop_front());
        beats++;
      end
    end
    start = 1'b0;

    check_eq("no_timeout", (cyc < 2000), 1);
    check_eq("beats", beats, total);
    check_eq("done_pulse", done, 1);
    check_eq("done_valid", tx_if.out_valid, 0);
    check_eq("done_busy", busy, 1);
    step();
    check_eq("done_clear", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_valid", tx_if.out_valid, 0);
  endtask

  initial begin
    logic [1599:0] st;

    rst             = 1'b1;
    start           = 1'b0;
    state_in        = '0;
    tx_if.out_ready = 1'b0;
    step();
    step();
    check_eq("reset_valid", tx_if.out_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_last", tx_if.out_last, 0);
    check_eq("reset_index", tx_if.out_index, 0);
    check_eq("reset_page", tx_if.out_page, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    step();
    check_eq("rst_prio_busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;

    // Ready without valid must leave the block idle.
    tx_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("idle_ready", busy, 0);
      check_eq("idle_ready_valid", tx_if.out_valid, 0);
    end

    st = '0;
    st[63:0] = 64'h1;
    run_xfer(st, 0, 1'b0, 1'b0);

    st = '0;
    st[64*24 +: 64] = 64'h8000_0000_0000_0000;
    run_xfer(st, 0, 1'b0, 1'b0);

    st = '0;
    st[63:0] = 64'h8000_0000_0000_0001;
    run_xfer(st, 1, 1'b0, 1'b0);

    run_xfer(rand_state(), 1, 1'b0, 1'b0);
    run_xfer(rand_state(), 0, 1'b1, 1'b0);
    run_xfer(rand_state(), 2, 1'b0, 1'b0);
    run_xfer(rand_state(), 2, 1'b0, 1'b1);
    run_xfer(rand_state(), 1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) run_xfer(rand_state(), 2, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
